priority_encode_pipelined: RTL and testbench

PRIORITY_ENCODE_PIPELINED -- requirements
Module: priority_encode_pipelined

---
 rtl/dts_search_pkg.sv | 12 +
 rtl/pe_radix4_cell.sv | 50 +++++
 rtl/priority_encode_pipelined.sv | 122 ++++++++++++
 tb/tb_priority_encode_pipelined.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dts_search_pkg.sv
// Shared constants for the radix-4 search/priority datapaths.
// Radix, bits consumed per reduction stage, and the padded input width helper.
package dts_search_pkg;

    localparam int RADIX          = 4;
    localparam int BITS_PER_STAGE = 2;

    function automatic int padded_width(input int stages);
        return 1 << (BITS_PER_STAGE * stages);
    endfunction

endpackage

// File: rtl/pe_radix4_cell.sv
// Combinational 4:1 reduction of (found, partial index) lanes.
// Lane layout is {partial_index, found}; output lane is {group, partial_index, found}.
module pe_radix4_cell
    import dts_search_pkg::*;
#(
    parameter int PIW = 0
) (
    input  logic [RADIX*(PIW+1)-1:0]    lane_i,
    output logic [PIW+BITS_PER_STAGE:0] lane_o
);

    localparam int LW = PIW + 1;

    logic [RADIX-1:0]          hit;
    logic [BITS_PER_STAGE-1:0] sel;
    logic                      any;

    // Scan high to low so the lowest-numbered hitting group wins.
    always_comb begin
        sel = '0;
        for (int g = 0; g < RADIX; g++) begin
            hit[g] = lane_i[g*LW];
        end
        any = |hit;
        for (int g = RADIX - 1; g >= 0; g--) begin
            if (hit[g]) begin
                sel = g[BITS_PER_STAGE-1:0];
            end
        end
    end

    // A lane without a hit always carries index 0, so sel=0 on a miss keeps that invariant.
    if (PIW > 0) begin : g_idx
        logic [PIW-1:0] sub;

        always_comb begin
            sub = '0;
            for (int g = 0; g < RADIX; g++) begin
                if (sel == g[BITS_PER_STAGE-1:0]) begin
                    sub = lane_i[g*LW+1 +: PIW];
                end
            end
        end

        assign lane_o = {sel, sub, any};
    end else begin : g_leaf
        assign lane_o = {sel, any};
    end

endmodule

// File: rtl/priority_encode_pipelined.sv
// Pipelined radix-4 lowest-set-bit encoder with valid/ready flow control.
// Optional PRIORITY_ENCODE_MISS_COUNT_EN adds a saturating miss_count output.
module priority_encode_pipelined
    import dts_search_pkg::*;
#(
    parameter int WIDTH  = 13,
    parameter int STAGES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(WIDTH)-1:0] index,
    output logic                     found
`ifdef PRIORITY_ENCODE_MISS_COUNT_EN
    ,
    output logic [15:0]              miss_count
`endif
);

    localparam int PADDED_WIDTH = padded_width(STAGES);
    localparam int IW           = $clog2(WIDTH);
    localparam int OUT_LW       = BITS_PER_STAGE * STAGES + 1;

    logic                    advance;
    logic [PADDED_WIDTH-1:0] in_pad;
    logic [OUT_LW-1:0]       last_lane;
    logic                    last_valid;

    assign advance  = !last_valid || out_ready;
    assign in_ready = advance;

    always_comb begin
        in_pad            = '0;
        in_pad[WIDTH-1:0] = in;
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_stg
        localparam int PIW  = BITS_PER_STAGE * s;
        localparam int LIN  = PIW + 1;
        localparam int LOUT = PIW + BITS_PER_STAGE + 1;
        localparam int GOUT = PADDED_WIDTH >> (BITS_PER_STAGE * (s + 1));

        logic [RADIX*GOUT*LIN-1:0] lanes_in;
        logic                      valid_in;
        logic [GOUT*LOUT-1:0]      lanes_red;
        logic [GOUT*LOUT-1:0]      lanes_d;
        logic [GOUT*LOUT-1:0]      lanes_q;
        logic                      valid_d;
        logic                      valid_q;

        if (s == 0) begin : g_first
            assign lanes_in = in_pad;
            assign valid_in = in_valid;
        end else begin : g_next
            assign lanes_in = g_stg[s-1].lanes_q;
            assign valid_in = g_stg[s-1].valid_q;
        end

        for (genvar g = 0; g < GOUT; g++) begin : g_cell
            pe_radix4_cell #(
                .PIW (PIW)
            ) u_cell (
                .lane_i (lanes_in[g*RADIX*LIN +: RADIX*LIN]),
                .lane_o (lanes_red[g*LOUT +: LOUT])
            );
        end

        // All stages move together; bubbles shift like words and are never squeezed out.
        always_comb begin
            valid_d = valid_q;
            lanes_d = lanes_q;
            if (advance) begin
                valid_d = valid_in;
                lanes_d = lanes_red;
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                valid_q <= 1'b0;
                lanes_q <= '0;
            end else begin
                valid_q <= valid_d;
                lanes_q <= lanes_d;
            end
        end
    end

    assign last_valid = g_stg[STAGES-1].valid_q;
    assign last_lane  = g_stg[STAGES-1].lanes_q;

    assign out_valid = last_valid;
    assign found     = last_valid & last_lane[0];
    assign index     = last_valid ? last_lane[IW:1] : '0;

`ifdef PRIORITY_ENCODE_MISS_COUNT_EN
    logic [15:0] miss_count_d;
    logic [15:0] miss_count_q;

    always_comb begin
        miss_count_d = miss_count_q;
        if (last_valid && out_ready && !last_lane[0] && (miss_count_q != 16'hFFFF)) begin
            miss_count_d = miss_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            miss_count_q <= '0;
        end else begin
            miss_count_q <= miss_count_d;
        end
    end

    assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_priority_encode_pipelined.sv
// Scoreboard bench for priority_encode_pipelined: directed vectors, stall, mid-stream reset, random traffic.
// Also checks miss_count when PRIORITY_ENCODE_MISS_COUNT_EN is defined.
module tb_priority_encode_pipelined;

    localparam int W  = 13;
    localparam int S  = 2;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] index;
    logic          found;
`ifdef PRIORITY_ENCODE_MISS_COUNT_EN
    logic [15:0]   miss_count;
    int            miss_exp = 0;
`endif

    always #5 clk = ~clk;

    priority_encode_pipelined #(
        .WIDTH  (W),
        .STAGES (S)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in         (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .index      (index),
        .found      (found)
`ifdef PRIORITY_ENCODE_MISS_COUNT_EN
        ,
        .miss_count (miss_count)
`endif
    );

    typedef struct {
        logic          f;
        logic [IW-1:0] i;
        int            due;
        bit            lat;
    } exp_t;

    exp_t          sb[$];
    int            errors = 0;
    int            checks = 0;
    int            cyc    = 0;
    logic          drv_f;
    logic [IW-1:0] drv_i;
    bit            drv_lat;
    bit            rnd_done;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model(input logic [W-1:0] v, output logic f, output logic [IW-1:0] i);
        f = 1'b0;
        i = '0;
        for (int k = W - 1; k >= 0; k--) begin
            if (v[k]) begin
                f = 1'b1;
                i = IW'(k);
            end
        end
    endfunction

    // Acceptance side: expected result enters the scoreboard when a word is taken.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && in_valid && in_ready) begin
            e.f   = drv_f;
            e.i   = drv_i;
            e.due = cyc + S;
            e.lat = drv_lat;
            sb.push_back(e);
        end
    end

    // Output side: every consumed result is popped and compared.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            if (out_valid) chk("out_valid_in_reset", out_valid, 0);
        end else if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got index=%0d found=%0b with empty scoreboard (t=%0t)",
                         index, found, $time);
            end else begin
                e = sb.pop_front();
                chk("found", found, e.f);
                chk("index", index, e.i);
                if (e.lat) chk("latency_cycle", cyc, e.due);
`ifdef PRIORITY_ENCODE_MISS_COUNT_EN
                if (!e.f) miss_exp++;
`endif
            end
        end
    end

    task automatic send(input logic [W-1:0] v, input logic f, input logic [IW-1:0] i, input bit lat);
        int n;
        bit acc;
        n       = 0;
        acc     = 1'b0;
        in_data = v;
        drv_f   = f;
        drv_i   = i;
        drv_lat = lat;
        in_valid = 1'b1;
        while (!acc) begin
            @(negedge clk);
            acc = in_ready && !reset;
            @(posedge clk);
            #1;
            n++;
            if (!acc && n > 2000) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: got no acceptance in %0d cycles, required acceptance", n);
                acc = 1'b1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d results outstanding, required 0", sb.size());
        end
    endtask

    logic [W-1:0]  dv [8] = '{13'h0048, 13'h0000, 13'h1000, 13'h0001, 13'h0010, 13'h1FFF, 13'h0800, 13'h0004};
    logic [IW-1:0] di [8] = '{4'd3,     4'd0,     4'd12,    4'd0,     4'd4,     4'd0,     4'd11,    4'd2};
    logic          df [8] = '{1'b1,     1'b0,     1'b1,     1'b1,     1'b1,     1'b1,     1'b1,     1'b1};

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        logic          rf;
        logic [IW-1:0] ri;
        logic [W-1:0]  rv;
        int            n;

        reset     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 13'h0001;
        out_ready = 1'b1;
        drv_f     = 1'b1;
        drv_i     = '0;
        drv_lat   = 1'b0;
        rnd_done  = 1'b0;

        // Reset state, with a word presented that must be dropped.
        #3;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_found", found, 0);
        chk("reset_index", index, 0);
        chk("reset_in_ready", in_ready, 1);
        repeat (3) @(posedge clk);
        #2 in_valid = 1'b0;
        #2 reset = 1'b0;
        @(posedge clk);
        #1 chk("first_edge_out_valid", out_valid, 0);

        // Directed back-to-back words with exact latency checks.
        for (int k = 0; k < 8; k++) send(dv[k], df[k], di[k], 1'b1);
        drain();
`ifdef PRIORITY_ENCODE_MISS_COUNT_EN
        chk("miss_count_directed", miss_count, 1);
`endif

        // Backpressure: output stalled five cycles with a third word waiting at the input.
        out_ready = 1'b0;
        fork
            begin
                send(13'h0200, 1'b1, 4'd9, 1'b0);
                send(13'h0006, 1'b1, 4'd1, 1'b0);
                send(13'h0100, 1'b1, 4'd8, 1'b0);
            end
            begin
                n = 0;
                @(negedge clk);
                while (!out_valid && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                chk("stall_out_valid_seen", out_valid, 1);
                repeat (5) begin
                    @(negedge clk);
                    chk("stall_in_ready", in_ready, 0);
                    chk("stall_out_valid", out_valid, 1);
                    chk("stall_found", found, 1);
                    chk("stall_index", index, 9);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Mid-stream asynchronous reset with two words in flight.
        out_ready = 1'b0;
        send(13'h0002, 1'b1, 4'd1, 1'b0);
        send(13'h0400, 1'b1, 4'd10, 1'b0);
        #2;
        reset = 1'b1;
        sb.delete();
        #1;
        chk("async_reset_out_valid", out_valid, 0);
        chk("async_reset_found", found, 0);
        chk("async_reset_index", index, 0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
`ifdef PRIORITY_ENCODE_MISS_COUNT_EN
        miss_exp = 0;
`endif
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1 chk("flushed_out_valid", out_valid, 0);

        // Random words with random gaps and random backpressure.
        fork
            begin
                for (int k = 0; k < 10000; k++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    case ($urandom_range(0, 3))
                        0:       rv = W'($urandom);
                        1:       rv = W'(13'h0001 << $urandom_range(0, W - 1));
                        2:       rv = '0;
                        default: rv = W'($urandom) & W'($urandom) & W'($urandom);
                    endcase
                    model(rv, rf, ri);
                    send(rv, rf, ri, 1'b0);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();
`ifdef PRIORITY_ENCODE_MISS_COUNT_EN
        chk("miss_count_random", miss_count, miss_exp);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
